// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - hazard controller hookup between pipeline datapath and sequencer
// Purpose: bundles the hazard inputs observed in ID/EX/MEM and the stage control outputs.
// Ports (via modports):
//   master - pipeline side: drives hazard sources, receives enables/flushes/stall_cnt/busy
//   slave  - sequencer side: observes hazard sources, drives enables/flushes/stall_cnt/busy
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic             ex_valid;
    logic [4:0]       ex_rd;
    logic             ex_is_load;
    logic             ex_multi;
    logic             ex_branch_taken;
    logic             mem_busy;
    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             memwb_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_flush;
    logic [CNT_W-1:0] stall_cnt;
    logic             busy;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        output ex_valid, ex_rd, ex_is_load, ex_multi, ex_branch_taken, mem_busy,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
        input  ifid_flush, idex_flush, exmem_flush, stall_cnt, busy
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        input  ex_valid, ex_rd, ex_is_load, ex_multi, ex_branch_taken, mem_busy,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
        output ifid_flush, idex_flush, exmem_flush, stall_cnt, busy
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush sequencer for the five-stage rv32 pipeline
// Purpose: resolves load-use, multi-cycle EX, data-memory wait and taken-branch hazards
//          by driving PC / IF-ID / ID-EX / EX-MEM / MEM-WB enables and bubble flushes.
// Ports:
//   clk   - clock, all state updates on rising edge
//   rst_n - synchronous active-low reset
//   hz    - slave side of pipe_hazard_ctrl_if (hazard inputs, stage controls,
//           saturating stall_cnt, busy while a multi-cycle op is in flight)
module pipe_hazard_ctrl #(
    parameter int MC_LAT = 4,
    parameter int CNT_W  = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipe_hazard_ctrl_if.slave    hz
);
    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_MULTI = 1'b1
    } state_t;

    // With a one-cycle latency the op completes in its first EX cycle, no wait state.
    localparam bit         MULTI_EN = (MC_LAT > 1);
    localparam logic [3:0] CNT_INIT = 4'(MC_LAT - 1);

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic ifid_flush, idex_flush, exmem_flush;
    logic load_use;

    always_comb begin
        load_use = hz.ex_valid && hz.ex_is_load && (hz.ex_rd != 5'd0) &&
                   ((hz.id_use_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                    (hz.id_use_rs2 && (hz.id_rs2 == hz.ex_rd)));
    end

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        state_d     = state_q;
        cnt_d       = cnt_q;

        if (!rst_n) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_en    = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            state_d     = ST_RUN;
            cnt_d       = 4'd0;
        end else if (hz.mem_busy) begin
            // Whole pipe frozen; MULTI countdown is frozen too.
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else if ((state_q == ST_MULTI) && (cnt_q > 4'd1)) begin
            // Hold IF..EX, send bubbles into MEM while older instructions drain.
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_flush = 1'b1;
            cnt_d       = cnt_q - 4'd1;
        end else if (state_q == ST_MULTI) begin
            // Final cycle: the op leaves EX and may itself redirect the PC.
            state_d = ST_RUN;
            cnt_d   = 4'd0;
            if (hz.ex_branch_taken) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end
        end else if (MULTI_EN && hz.ex_valid && hz.ex_multi) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_flush = 1'b1;
            state_d     = ST_MULTI;
            cnt_d       = CNT_INIT;
        end else if (hz.ex_branch_taken) begin
            // Redirect wins over load-use: the dependent instruction is squashed anyway.
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    // Memory wait is not a pipeline hazard stall and is excluded from the count.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!rst_n) begin
            stall_cnt_d = '0;
        end else if (!hz.mem_busy && !pc_en && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            cnt_q       <= 4'd0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign hz.pc_en       = pc_en;
    assign hz.ifid_en     = ifid_en;
    assign hz.idex_en     = idex_en;
    assign hz.exmem_en    = exmem_en;
    assign hz.memwb_en    = memwb_en;
    assign hz.ifid_flush  = ifid_flush;
    assign hz.idex_flush  = idex_flush;
    assign hz.exmem_flush = exmem_flush;
    assign hz.stall_cnt   = stall_cnt_q;
    assign hz.busy        = rst_n && (state_q == ST_MULTI);
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard testbench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.CNT_W(32)) bus ();
    pipe_hazard_ctrl_if #(.CNT_W(4))  bus_s ();

    pipe_hazard_ctrl #(.MC_LAT(4), .CNT_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (bus.slave)
    );

    pipe_hazard_ctrl #(.MC_LAT(4), .CNT_W(4)) dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (bus_s.slave)
    );

    assign bus_s.id_rs1          = bus.id_rs1;
    assign bus_s.id_rs2          = bus.id_rs2;
    assign bus_s.id_use_rs1      = bus.id_use_rs1;
    assign bus_s.id_use_rs2      = bus.id_use_rs2;
    assign bus_s.ex_valid        = bus.ex_valid;
    assign bus_s.ex_rd           = bus.ex_rd;
    assign bus_s.ex_is_load      = bus.ex_is_load;
    assign bus_s.ex_multi        = bus.ex_multi;
    assign bus_s.ex_branch_taken = bus.ex_branch_taken;
    assign bus_s.mem_busy        = bus.mem_busy;

    // {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush}
    localparam logic [7:0] C_RST  = 8'b00000_111;
    localparam logic [7:0] C_NORM = 8'b11111_000;
    localparam logic [7:0] C_MEMW = 8'b00000_000;
    localparam logic [7:0] C_MSTL = 8'b00011_001;
    localparam logic [7:0] C_LU   = 8'b00111_010;
    localparam logic [7:0] C_BR   = 8'b11111_110;

    typedef struct {
        string       name;
        logic [7:0]  ctrl;
        logic        busy;
        logic [31:0] cnt;
        logic [3:0]  cnt_sat;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Monitor: the controller presents a control vector every cycle; compare mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [7:0] act;
            e = exp_q.pop_front();
            act = {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
                   bus.ifid_flush, bus.idex_flush, bus.exmem_flush};
            checks++;
            if (act !== e.ctrl) begin
                errors++;
                $display("FAIL %s ctrl got %b want %b", e.name, act, e.ctrl);
            end
            checks++;
            if (bus.busy !== e.busy) begin
                errors++;
                $display("FAIL %s busy got %b want %b", e.name, bus.busy, e.busy);
            end
            checks++;
            if (bus.stall_cnt !== e.cnt) begin
                errors++;
                $display("FAIL %s stall_cnt got %0d want %0d", e.name, bus.stall_cnt, e.cnt);
            end
            checks++;
            if (bus_s.stall_cnt !== e.cnt_sat) begin
                errors++;
                $display("FAIL %s stall_cnt_w4 got %0d want %0d", e.name, bus_s.stall_cnt, e.cnt_sat);
            end
        end
    end

    task automatic idle_inputs();
        bus.id_rs1          = 5'd0;
        bus.id_rs2          = 5'd0;
        bus.id_use_rs1      = 1'b0;
        bus.id_use_rs2      = 1'b0;
        bus.ex_valid        = 1'b0;
        bus.ex_rd           = 5'd0;
        bus.ex_is_load      = 1'b0;
        bus.ex_multi        = 1'b0;
        bus.ex_branch_taken = 1'b0;
        bus.mem_busy        = 1'b0;
    endtask

    task automatic load_inputs(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                               input logic [4:0] rs2, input logic u2);
        bus.ex_valid   = 1'b1;
        bus.ex_is_load = 1'b1;
        bus.ex_rd      = rd;
        bus.id_rs1     = rs1;
        bus.id_use_rs1 = u1;
        bus.id_rs2     = rs2;
        bus.id_use_rs2 = u2;
    endtask

    // Inputs are already set; queue the expectation and run one clock.
    task automatic step(input string name, input logic [7:0] ctrl, input logic busy,
                        input int cnt);
        exp_t e;
        e.name    = name;
        e.ctrl    = ctrl;
        e.busy    = busy;
        e.cnt     = 32'(cnt);
        e.cnt_sat = (cnt > 15) ? 4'd15 : 4'(cnt);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        step("reset", C_RST, 1'b0, 0);
        rst_n = 1'b1;
        step("idle_after_reset", C_NORM, 1'b0, 0);

        // Load-use on rs2, then rd=0, rs1 match, and rs1 match without use.
        load_inputs(5'd5, 5'd0, 1'b0, 5'd5, 1'b1);
        step("lu_rs2", C_LU, 1'b0, 0);
        idle_inputs();
        step("lu_rs2_after", C_NORM, 1'b0, 1);
        load_inputs(5'd0, 5'd0, 1'b0, 5'd0, 1'b1);
        step("lu_rd0", C_NORM, 1'b0, 1);
        load_inputs(5'd7, 5'd7, 1'b1, 5'd3, 1'b1);
        step("lu_rs1", C_LU, 1'b0, 1);
        idle_inputs();
        step("lu_rs1_after", C_NORM, 1'b0, 2);
        load_inputs(5'd7, 5'd7, 1'b0, 5'd3, 1'b1);
        step("lu_nouse", C_NORM, 1'b0, 2);
        idle_inputs();

        // Multi-cycle op, MC_LAT=4; ex_multi/branch stay high to show they are ignored.
        bus.ex_valid = 1'b1;
        bus.ex_multi = 1'b1;
        step("multi_t0", C_MSTL, 1'b0, 2);
        bus.ex_branch_taken = 1'b1;
        step("multi_t1", C_MSTL, 1'b1, 3);
        step("multi_t2", C_MSTL, 1'b1, 4);
        bus.ex_branch_taken = 1'b0;
        step("multi_t3", C_NORM, 1'b1, 5);
        idle_inputs();
        step("multi_done", C_NORM, 1'b0, 5);

        // Memory wait at cnt=2 freezes the countdown; completion also redirects.
        bus.ex_valid = 1'b1;
        bus.ex_multi = 1'b1;
        step("mw_t0", C_MSTL, 1'b0, 5);
        step("mw_t1", C_MSTL, 1'b1, 6);
        bus.mem_busy = 1'b1;
        step("mw_wait0", C_MEMW, 1'b1, 7);
        step("mw_wait1", C_MEMW, 1'b1, 7);
        bus.mem_busy = 1'b0;
        step("mw_t2", C_MSTL, 1'b1, 7);
        bus.ex_branch_taken = 1'b1;
        step("mw_done_br", C_BR, 1'b1, 8);
        idle_inputs();
        step("mw_run", C_NORM, 1'b0, 8);

        // Branch beats load-use in the same cycle.
        load_inputs(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
        bus.ex_branch_taken = 1'b1;
        step("br_vs_lu", C_BR, 1'b0, 8);
        bus.ex_branch_taken = 1'b0;
        bus.mem_busy = 1'b1;
        step("memwait_lu", C_MEMW, 1'b0, 8);
        idle_inputs();
        step("br_after", C_NORM, 1'b0, 8);

        // Reset in the middle of MULTI.
        bus.ex_valid = 1'b1;
        bus.ex_multi = 1'b1;
        step("mid_multi", C_MSTL, 1'b0, 8);
        rst_n = 1'b0;
        step("mid_reset", C_RST, 1'b0, 9);
        rst_n = 1'b1;
        idle_inputs();
        step("post_reset", C_NORM, 1'b0, 0);

        // Saturation: 20 load-use stalls; 4-bit counter pins at 15.
        for (int i = 0; i < 20; i++) begin
            load_inputs(5'd9, 5'd0, 1'b0, 5'd9, 1'b1);
            step("sat_lu", C_LU, 1'b0, i);
            idle_inputs();
            step("sat_gap", C_NORM, 1'b0, i + 1);
        end
        step("sat_hold0", C_NORM, 1'b0, 20);
        step("sat_hold1", C_NORM, 1'b0, 20);

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain pending %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the rv32 five-stage pipeline.
- Drives the enable and flush controls of the PC and the four inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Resolves load-use hazards, multi-cycle EX operations, data-memory wait and taken-branch redirects.
- Keeps a saturating stall-cycle performance counter.

Parameters:
MC_LAT, 4, latency in cycles of a multi-cycle EX operation (mul/div); legal range 1..15
CNT_W, 32, width of the stall performance counter

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
id_rs1  in  5  source register 1 of the instruction in ID
id_rs2  in  5  source register 2 of the instruction in ID
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
ex_valid  in  1  EX holds a real (non-bubble) instruction
ex_rd  in  5  destination register of the EX instruction
ex_is_load  in  1  EX instruction is a load
ex_multi  in  1  EX instruction is a multi-cycle op
ex_branch_taken  in  1  EX resolved a taken branch/jump; PC loads the target when pc_en=1
mem_busy  in  1  data memory not ready this cycle
pc_en  out  1  PC register update enable
ifid_en, idex_en, exmem_en, memwb_en  out  1 each  stage register load enables
ifid_flush, idex_flush, exmem_flush  out  1 each  load a bubble (valid=0) when the matching en=1
stall_cnt  out  CNT_W  cycles with pc_en=0, saturating
busy  out  1  high while in state MULTI

Behaviour:
- Reset is one clock and one synchronous active-low reset; rst_n low at a rising edge resets state.
- State register: RUN / MULTI, plus a 4-bit down-counter cnt.
- Control outputs are combinational from state, cnt and inputs.
- Priority, highest first; first match sets all controls, and any unlisted enable = 1 and unlisted flush = 0:
  1. rst_n=0: all en=0; ifid_flush, idex_flush, exmem_flush = 1; busy=0. Next edge: state=RUN, cnt=0, stall_cnt=0.
  2. mem_busy=1: all en=0, all flush=0. State, cnt and stall_cnt are held. stall_cnt does NOT count memory wait.
  3. MULTI with cnt>1: pc_en=ifid_en=idex_en=0; exmem_en=1 with exmem_flush=1 (bubble to MEM); memwb_en=1; cnt<=cnt-1.
  4. MULTI with cnt==1: EX op completes this cycle, all en=1, no flush; next state RUN, cnt<=0. If ex_branch_taken=1, apply rule 6 in this same cycle.
  5. RUN, ex_valid=1, ex_multi=1, MC_LAT>1: same controls as rule 3; next state MULTI with cnt<=MC_LAT-1. MC_LAT=1 never enters MULTI.
  6. ex_branch_taken=1 on a completing cycle (RUN, or rule 4): pc_en=1; ifid_flush=idex_flush=1; remaining en=1. Overrides the load-use check (the dependent instruction is discarded).
  7. Load-use: RUN, ex_valid=1, ex_is_load=1, ex_rd!=0, and (id_use_rs1 & id_rs1==ex_rd or id_use_rs2 & id_rs2==ex_rd):
     - pc_en=ifid_en=0;
     - idex_en=1 with idex_flush=1;
     - exmem_en=memwb_en=1.
     - Exactly one bubble per hazard: on the next cycle the load has left EX.
  8. Otherwise all en=1, all flush=0.
- ex_branch_taken and ex_multi are ignored while cnt>1 in MULTI.
- stall_cnt increments by 1 on each edge where rst_n=1, mem_busy=0 and pc_en=0. It holds at 2^CNT_W-1.
- A mid-MULTI reset returns to RUN with no residual stall.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles. Expect all en=0, all three flush=1, stall_cnt=0, busy=0. Release, then idle cycle: all en=1, all flush=0.
- Load-use: ex_valid=1, ex_is_load=1, ex_rd=5, id_rs2=5, id_use_rs2=1. Expect one cycle of pc_en=0, ifid_en=0, idex_flush=1, then normal; stall_cnt=1. Repeat with ex_rd=0: no stall.
- Multi-cycle op, MC_LAT=4: ex_multi=1 at cycle t. Expect pc_en=0 and exmem_flush=1 at cycles t..t+2, busy=1 at t+1..t+3, all en=1 at t+3, then RUN; stall_cnt=3.
- mem_busy=1 for 2 cycles during MULTI (cnt=2): all en=0, cnt frozen, stall_cnt unchanged. Completion is delayed by exactly 2 cycles.
- Branch vs load-use, same cycle: ex_branch_taken=1 with a load-use match. Expect pc_en=1, ifid_flush=idex_flush=1, no stall; stall_cnt unchanged.
- Saturation, CNT_W=4: 20 load-use stalls. Expect stall_cnt=15 and holding.
